// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader
//   Reads one XWIDTH x YHEIGHT frame out of a double-buffered frame memory
//   and turns it into a raster-order valid/ready pixel stream for the
//   display side.
//   Buffer 0 starts at BASE_ADDR and buffer 1 follows it directly, with one
//   pixel per address.
//   Reads are issued through an in-order request/response port. Returned
//   pixels are prefetched into a small FIFO.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start_frame,buf_sel begin a frame from the selected buffer (IDLE only)
//   busy, frame_done    frame in progress / one-cycle completion pulse
//   rd_req, rd_addr     read request and address (address held until granted)
//   rd_gnt              memory accepts the request this cycle
//   rd_valid, rd_data   read response, returned in request order
//   pix_valid/ready     output pixel handshake
//   pix_data            RGB888 colour {R,G,B}
//   pix_x, pix_y        pixel position
//   pix_sof/eol/eof     start of frame, end of line, end of frame markers
//   rd_err              sticky flag for a response with nothing outstanding
module frame_buffer_reader #(
  parameter int          XWIDTH     = 320,
  parameter int          YHEIGHT    = 240,
  parameter int          PIXWIDTH   = 24,
  parameter int          ADDR_W     = 24,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_frame,
  input  logic                buf_sel,
  output logic                busy,
  output logic                frame_done,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_gnt,
  input  logic                rd_valid,
  input  logic [PIXWIDTH-1:0] rd_data,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [PIXWIDTH-1:0] pix_data,
  output logic [8:0]          pix_x,
  output logic [7:0]          pix_y,
  output logic                pix_sof,
  output logic                pix_eol,
  output logic                pix_eof,
  output logic                rd_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [8:0]        X_LAST    = 9'(XWIDTH - 1);
  localparam logic [7:0]        Y_LAST    = 8'(YHEIGHT - 1);
  localparam logic [ADDR_W-1:0] BUF0_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BUF1_ADDR = ADDR_W'(BASE_ADDR + XWIDTH * YHEIGHT);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t              state, state_next;
  logic [8:0]          req_x;
  logic [7:0]          req_y;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    outstanding;
  logic [CNT_W-1:0]    fifo_count;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PIXWIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [8:0]          out_x;
  logic [7:0]          out_y;
  logic                err_q;

  logic start_acc, req_fire, req_last, rsp_fire, spurious, pix_fire, out_last;

  // Handshake decodes. A request is raised only when every slot that could
  // receive data (in flight or already buffered) still fits in the FIFO.
  // That is why the FIFO can never overflow.
  assign start_acc = (state == S_IDLE) && start_frame;
  assign rd_req    = (state == S_FETCH) && ((outstanding + fifo_count) < DEPTH_C);
  assign req_fire  = rd_req && rd_gnt;
  assign req_last  = (req_x == X_LAST) && (req_y == Y_LAST);
  assign rsp_fire  = rd_valid && (outstanding != '0);
  assign spurious  = rd_valid && (outstanding == '0);
  assign pix_valid = (fifo_count != '0);
  assign pix_fire  = pix_valid && pix_ready;
  assign out_last  = (out_x == X_LAST) && (out_y == Y_LAST);

  // Output stream fields come from the FIFO head and the output-side
  // position counters. They are gated so that an empty FIFO shows zeros.
  assign busy     = (state != S_IDLE);
  assign rd_addr  = addr_q;
  assign rd_err   = err_q;
  assign pix_data = pix_valid ? fifo_mem[rd_ptr] : '0;
  assign pix_x    = out_x;
  assign pix_y    = out_y;
  assign pix_sof  = pix_valid && (out_x == '0) && (out_y == '0);
  assign pix_eol  = pix_valid && (out_x == X_LAST);
  assign pix_eof  = pix_valid && out_last;

  // State register for the frame sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic. FETCH ends once the final address has been granted.
  // DRAIN waits for the final pixel to leave. DONE lasts one cycle and
  // produces the completion pulse.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE:  if (start_frame) state_next = S_FETCH;
      S_FETCH: if (req_fire && req_last) state_next = S_DRAIN;
      S_DRAIN: if (pix_fire && out_last) state_next = S_DONE;
      S_DONE: begin
        frame_done = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Request-side position and running address. The buffers are flat and
  // raster ordered, so the address only needs to step by one per grant.
  // The x/y counters are kept solely to spot the final request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_x  <= '0;
      req_y  <= '0;
      addr_q <= '0;
    end else if (start_acc) begin
      req_x  <= '0;
      req_y  <= '0;
      addr_q <= buf_sel ? BUF1_ADDR : BUF0_ADDR;
    end else if (req_fire) begin
      addr_q <= addr_q + ADDR_W'(1);
      if (req_x == X_LAST) begin
        req_x <= '0;
        req_y <= req_y + 8'd1;
      end else begin
        req_x <= req_x + 9'd1;
      end
    end
  end

  // Count of granted reads whose data has not yet come back. A response
  // with nothing outstanding is not counted here. It only raises rd_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      unique case ({req_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // FIFO pointers and occupancy. A push and a pop in the same cycle are
  // both honoured, and in that case the occupancy is left unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (rsp_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (pix_fire) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({rsp_fire, pix_fire})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage. Contents are only ever visible through a valid head
  // entry, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (rsp_fire) fifo_mem[wr_ptr] <= rd_data;
  end

  // Output-side raster position. It advances on each accepted pixel,
  // independently of how far ahead the request side has run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_x <= '0;
      out_y <= '0;
    end else if (start_acc) begin
      out_x <= '0;
      out_y <= '0;
    end else if (pix_fire) begin
      if (out_x == X_LAST) begin
        out_x <= '0;
        out_y <= out_y + 8'd1;
      end else begin
        out_x <= out_x + 9'd1;
      end
    end
  end

  // Sticky protocol error flag. A stray response arriving in the same cycle
  // as an accepted start still leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      if (start_acc) err_q <= 1'b0;
      if (spurious)  err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb_frame_buffer_reader
//   Runs a reduced-size frame reader against a behavioural memory and a
//   display model.
//   Pixel k of a frame is expected at x = k % XW and y = k / XW.
//   Its colour is expected to be mem_fn(frame base + k).
module tb_frame_buffer_reader;

  localparam int XW    = 24;
  localparam int YH    = 10;
  localparam int NPIX  = XW * YH;
  localparam int DEPTH = 4;
  localparam int AW    = 24;
  localparam int PW    = 24;
  localparam int BASE  = 32'h1000;

  logic          clk = 1'b0;
  logic          rst, start_frame, buf_sel;
  logic          busy, frame_done, rd_req, rd_gnt, rd_valid;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data, pix_data;
  logic          pix_valid, pix_ready, pix_sof, pix_eol, pix_eof, rd_err;
  logic [8:0]    pix_x;
  logic [7:0]    pix_y;

  int checks = 0;
  int errors = 0;

  int gnt_pct     = 100;
  int ready_pct   = 100;
  int max_lat     = 1;
  bit force_stall = 1'b0;
  bit inject_bad  = 1'b0;

  int frame_base = BASE;
  int req_idx    = 0;
  int pix_idx    = 0;
  int cyc        = 0;

  frame_buffer_reader #(
    .XWIDTH(XW), .YHEIGHT(YH), .PIXWIDTH(PW), .ADDR_W(AW),
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start_frame(start_frame), .buf_sel(buf_sel),
    .busy(busy), .frame_done(frame_done), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_eof(pix_eof), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  // Memory contents: a scrambled but deterministic function of the address.
  function automatic logic [PW-1:0] mem_fn(input logic [AW-1:0] a);
    logic [31:0] h;
    h = {8'h00, a} * 32'h9E3779B1;
    h = h ^ (h >> 15);
    return h[PW-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_frame_done"}, frame_done, 0);
    checkOutput({tag, "_rd_req"}, rd_req, 0);
    checkOutput({tag, "_rd_addr"}, rd_addr, 0);
    checkOutput({tag, "_pix_valid"}, pix_valid, 0);
    checkOutput({tag, "_pix_data"}, pix_data, 0);
    checkOutput({tag, "_pix_x"}, pix_x, 0);
    checkOutput({tag, "_pix_y"}, pix_y, 0);
    checkOutput({tag, "_pix_sof"}, pix_sof, 0);
    checkOutput({tag, "_pix_eol"}, pix_eol, 0);
    checkOutput({tag, "_pix_eof"}, pix_eof, 0);
    checkOutput({tag, "_rd_err"}, rd_err, 0);
  endtask

  // Pulses start_frame for one cycle and points the model at the new frame.
  task automatic applyStimulus(input bit sel);
    @(posedge clk);
    #1;
    frame_base  = BASE + (sel ? NPIX : 0);
    req_idx     = 0;
    pix_idx     = 0;
    start_frame = 1'b1;
    buf_sel     = sel;
    @(posedge clk);
    #1;
    start_frame = 1'b0;
    buf_sel     = $urandom_range(1, 0) != 0;
  endtask

  task automatic wait_frame(input int budget, input string tag);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (frame_done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s frame_done timeout observed=none after %0d cycles expected=pulse",
             tag, budget);
    end else begin
      checkOutput({tag, "_req_count"}, req_idx, NPIX);
      checkOutput({tag, "_pix_count"}, pix_idx, NPIX);
      checkOutput({tag, "_busy_in_done"}, busy, 1);
      checkOutput({tag, "_rd_err"}, rd_err, 0);
      @(negedge clk);
      checkOutput({tag, "_busy_after"}, busy, 0);
      checkOutput({tag, "_rd_req_after"}, rd_req, 0);
    end
  endtask

  // Memory responder and display monitor. Handshakes are observed at the
  // falling edge, and new responses and ready/grant values are driven just
  // after the rising edge.
  initial begin
    logic [AW-1:0] pend_addr[$];
    int            pend_due[$];
    bit            addr_hold, stall_prev, done_due;
    logic [AW-1:0] held_addr;
    logic [PW-1:0] held_pix;
    int            k;
    addr_hold  = 1'b0;
    stall_prev = 1'b0;
    done_due   = 1'b0;
    held_addr  = '0;
    held_pix   = '0;
    rd_gnt     = 1'b1;
    rd_valid   = 1'b0;
    rd_data    = '0;
    pix_ready  = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        addr_hold  = 1'b0;
        stall_prev = 1'b0;
        done_due   = 1'b0;
      end else begin
        if (addr_hold && rd_req) checkOutput("rd_addr_hold", rd_addr, held_addr);
        addr_hold = rd_req && !rd_gnt;
        held_addr = rd_addr;
        if (rd_req && rd_gnt) begin
          checkOutput("rd_addr", rd_addr, frame_base + req_idx);
          req_idx++;
          checkOutput("credit", (req_idx - pix_idx) <= DEPTH, 1);
          pend_addr.push_back(rd_addr);
          pend_due.push_back(cyc + int'($urandom_range(max_lat, 1)));
        end
        if (stall_prev) begin
          checkOutput("pix_valid_hold", pix_valid, 1);
          checkOutput("pix_data_hold", pix_data, held_pix);
        end
        stall_prev = pix_valid && !pix_ready;
        held_pix   = pix_data;
        if (frame_done || done_due) checkOutput("frame_done", frame_done, done_due);
        done_due = 1'b0;
        if (pix_valid && pix_ready) begin
          k = pix_idx;
          if (k >= NPIX) begin
            checkOutput("extra_pixel", k, NPIX - 1);
          end else begin
            checkOutput("pix_data", pix_data, mem_fn(AW'(frame_base + k)));
            checkOutput("pix_x", pix_x, k % XW);
            checkOutput("pix_y", pix_y, k / XW);
            checkOutput("pix_sof", pix_sof, k == 0);
            checkOutput("pix_eol", pix_eol, (k % XW) == XW - 1);
            checkOutput("pix_eof", pix_eof, k == NPIX - 1);
            if (k == NPIX - 1) done_due = 1'b1;
          end
          pix_idx++;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        rd_valid = 1'b0;
      end else if (inject_bad) begin
        rd_valid   = 1'b1;
        rd_data    = PW'($urandom);
        inject_bad = 1'b0;
      end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
        rd_valid = 1'b1;
        rd_data  = mem_fn(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        rd_valid = 1'b0;
        rd_data  = PW'($urandom);
      end
      rd_gnt    = $urandom_range(99, 0) < gnt_pct;
      pix_ready = !force_stall && ($urandom_range(99, 0) < ready_pct);
    end
  end

  // Directed sequence of scenarios.
  initial begin
    rst         = 1'b1;
    start_frame = 1'b0;
    buf_sel     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_rd_req", rd_req, 0);
    end

    $display("[TB] full-rate frame from buffer 0");
    applyStimulus(1'b0);
    wait_frame(NPIX + 10, "buf0");

    $display("[TB] full-rate frame from buffer 1");
    applyStimulus(1'b1);
    wait_frame(NPIX + 10, "buf1");

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(1'b1);
    repeat (30) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("post_reset_busy", busy, 0);
      checkOutput("post_reset_rd_req", rd_req, 0);
    end
    checkOutput("post_reset_rd_err", rd_err, 0);

    $display("[TB] downstream stall at frame start");
    force_stall = 1'b1;
    applyStimulus(1'b0);
    repeat (19) @(negedge clk);
    checkOutput("stall_grants", req_idx, DEPTH);
    checkOutput("stall_rd_req", rd_req, 0);
    checkOutput("stall_pix_valid", pix_valid, 1);
    checkOutput("stall_sof", pix_sof, 1);
    force_stall = 1'b0;
    wait_frame(NPIX + 40, "stall");

    $display("[TB] random grant, latency and ready");
    gnt_pct   = 50;
    max_lat   = 6;
    ready_pct = 70;
    applyStimulus(1'b1);
    wait_frame(NPIX * 16, "rand1");
    applyStimulus(1'b0);
    wait_frame(NPIX * 16, "rand0");

    $display("[TB] start while busy and stray response");
    gnt_pct   = 100;
    max_lat   = 1;
    ready_pct = 100;
    applyStimulus(1'b0);
    repeat (30) @(negedge clk);
    @(posedge clk);
    #1;
    start_frame = 1'b1;
    buf_sel     = 1'b1;
    @(posedge clk);
    #1;
    start_frame = 1'b0;
    @(negedge clk);
    checkOutput("restart_busy", busy, 1);
    wait_frame(NPIX + 10, "restart_ignored");

    checkOutput("rd_err_clear", rd_err, 0);
    inject_bad = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rd_err_set", rd_err, 1);
    repeat (5) @(negedge clk);
    checkOutput("rd_err_sticky", rd_err, 1);
    checkOutput("rd_err_idle_busy", busy, 0);
    applyStimulus(1'b1);
    @(negedge clk);
    checkOutput("rd_err_cleared_by_start", rd_err, 0);
    wait_frame(NPIX + 10, "after_err");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
